// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer for the IF stage.
// Holds the PC, issues one request at a time, and captures responses into a one-entry IF/ID register.
module pc_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int                INST_BYTES = 4,
   parameter int                RESET_HOLD = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              if_req_o,
   output logic [ADDR_W-1:0] if_addr_o,
   input  logic              if_ack_i,
   input  logic [INST_W-1:0] if_rdata_i,
   output logic              ce_o,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o
);

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES) - ADDR_W'(1));
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_ISSUE,
      S_WAIT,
      S_KILL
   } state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] target;
   logic              slot_free;
   logic              ack_take;

   assign target    = redirect_pc_i & ALIGN_MASK;
   assign slot_free = ~inst_valid_o | ~stall_i;
   assign if_req_o  = ~rst & (state == S_ISSUE) & ~redirect_i & slot_free;
   assign if_addr_o = pc;
   // Only a live response in WAIT without a simultaneous redirect reaches the output register.
   assign ack_take  = (state == S_WAIT) & if_ack_i & ~redirect_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_HOLD;
         hold_cnt     <= '0;
         pc           <= RESET_VEC;
         fetch_addr   <= RESET_VEC;
         ce_o         <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
      end else begin
         if (ack_take) begin
            inst_o       <= if_rdata_i;
            inst_pc_o    <= fetch_addr;
            inst_valid_o <= 1'b1;
         end else if (redirect_i || !stall_i) begin
            inst_valid_o <= 1'b0;
         end

         if (redirect_i) begin
            pc <= target;
         end else if (ack_take) begin
            pc <= fetch_addr + ADDR_W'(INST_BYTES);
         end

         case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state <= S_ISSUE;
                  ce_o  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_ISSUE: begin
               if (if_req_o) begin
                  fetch_addr <= pc;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (if_ack_i) begin
                  state <= S_ISSUE;
               end else if (redirect_i) begin
                  state <= S_KILL;
               end
            end
            S_KILL: begin
               // The stale response is dropped here; a fresh redirect only moves the PC.
               if (if_ack_i) begin
                  state <= S_ISSUE;
               end
            end
            default: state <= S_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus random stall/redirect/latency traffic,
// checked against a transaction-level model of the fetch stream and a memory responder.
module tb_pc_fetch_unit;

   localparam int          AW = 32;
   localparam int          IW = 32;
   localparam int          RH = 2;
   localparam logic [31:0] RV = 32'h100;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall_i;
   logic          redirect_i;
   logic [AW-1:0] redirect_pc_i;
   logic          if_req_o;
   logic [AW-1:0] if_addr_o;
   logic          if_ack_i;
   logic [IW-1:0] if_rdata_i;
   logic          ce_o;
   logic          inst_valid_o;
   logic [IW-1:0] inst_o;
   logic [AW-1:0] inst_pc_o;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .ADDR_W    (AW),
      .INST_W    (IW),
      .RESET_VEC (RV),
      .INST_BYTES(4),
      .RESET_HOLD(RH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .if_req_o     (if_req_o),
      .if_addr_o    (if_addr_o),
      .if_ack_i     (if_ack_i),
      .if_rdata_i   (if_rdata_i),
      .ce_o         (ce_o),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o)
   );

   int n_vec = 0;
   int n_err = 0;

   // memory responder
   logic        mem_pend;
   int          mem_cnt;
   logic [31:0] mem_data;
   int          lat_cfg;

   // reference model of the fetch stream
   int          m_hold;
   logic        m_ce, m_valid, m_zero, m_out, m_stale;
   logic [31:0] m_inst, m_pc, m_next, m_addr;
   logic [31:0] req_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_hold  = RH;
      m_ce    = 1'b0;
      m_valid = 1'b0;
      m_zero  = 1'b1;
      m_inst  = '0;
      m_pc    = '0;
      m_next  = RV;
      m_out   = 1'b0;
      m_stale = 1'b0;
   endtask

   task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic r);
      logic exp_req;
      logic req;
      @(negedge clk);
      rst           = r;
      stall_i       = st;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      if_ack_i      = mem_pend && (mem_cnt == 0);
      if_rdata_i    = if_ack_i ? mem_data : $urandom;
      #1;
      exp_req = !r && m_ce && !m_out && !rd && (!m_valid || !st);
      chk("ce", 64'(ce_o), 64'(m_ce));
      chk("req", 64'(if_req_o), 64'(exp_req));
      if (exp_req && if_req_o) chk("addr", 64'(if_addr_o), 64'(m_next));
      chk("valid", 64'(inst_valid_o), 64'(m_valid));
      if (m_valid || m_zero) begin
         chk("inst", 64'(inst_o), 64'(m_inst));
         chk("inst_pc", 64'(inst_pc_o), 64'(m_pc));
      end
      req = if_req_o;
      if (req) req_q.push_back(if_addr_o);

      if (if_ack_i) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (req) begin
         mem_pend = 1'b1;
         mem_cnt  = ((lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg) - 1;
         mem_data = $urandom;
      end

      if (r) begin
         model_reset();
      end else begin
         if (m_valid && !st) m_valid = 1'b0;
         if (rd) begin
            m_valid = 1'b0;
            m_next  = rpc & ~32'h3;
            if (m_out) m_stale = 1'b1;
         end
         if (if_ack_i && m_out) begin
            if (!m_stale) begin
               m_valid = 1'b1;
               m_zero  = 1'b0;
               m_inst  = if_rdata_i;
               m_pc    = m_addr;
               m_next  = m_addr + 32'd4;
            end
            m_out = 1'b0;
         end
         if (req) begin
            m_out   = 1'b1;
            m_stale = 1'b0;
            m_addr  = m_next;
         end
         if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_ce = 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      if_ack_i = 1'b0; if_rdata_i = '0;
      mem_pend = 1'b0; mem_cnt = 0; mem_data = '0; lat_cfg = 1; m_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      cycle(0, 0, 0, 1);

      // reset release, hold-off and zero-wait sequential fetch
      for (int i = 0; i < 20 && !(m_valid && m_pc == 32'h104); i++) cycle(0, 0, 0, 0);
      chk("seq_count", 64'(req_q.size()), 64'd2);
      chk("seq_first", 64'(req_q[0]), 64'h100);
      chk("seq_second", 64'(req_q[1]), 64'h104);

      // stall with 0x104 held in the output register
      repeat (5) cycle(1, 0, 0, 0);
      chk("stall_noreq", 64'(req_q.size()), 64'd2);
      cycle(0, 0, 0, 0);
      chk("unstall_req", 64'(req_q[$]), 64'h108);

      // redirect while waiting on a 3-cycle response
      lat_cfg = 3;
      for (int i = 0; i < 20 && !(m_out && mem_cnt == 2); i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 32'h2002, 0);
      req_q.delete();
      repeat (8) cycle(0, 0, 0, 0);
      chk("kill_redir_req", 64'(req_q[0]), 64'h2000);

      // redirect in the same cycle as the ack
      lat_cfg = 2;
      for (int i = 0; i < 20 && !(m_out && !m_stale && mem_pend && mem_cnt == 0); i++)
         cycle(0, 0, 0, 0);
      cycle(0, 1, 32'h400, 0);
      req_q.delete();
      cycle(0, 0, 0, 0);
      chk("simul_count", 64'(req_q.size()), 64'd1);
      chk("simul_req", 64'(req_q[0]), 64'h400);

      // address wrap-around
      lat_cfg = 1;
      for (int i = 0; i < 20 && m_out; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 32'hFFFF_FFFC, 0);
      req_q.delete();
      repeat (6) cycle(0, 0, 0, 0);
      chk("wrap_first", 64'(req_q[0]), 64'hFFFF_FFFC);
      chk("wrap_second", 64'(req_q[1]), 64'h0);

      // reset while a fetch is outstanding; the late ack lands during hold-off
      lat_cfg = 2;
      for (int i = 0; i < 20 && !(m_out && mem_pend && mem_cnt == 1); i++) cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      req_q.delete();
      cycle(0, 0, 0, 0);
      chk("rst_valid", 64'(inst_valid_o), 64'd0);
      chk("rst_inst", 64'(inst_o), 64'd0);
      repeat (6) cycle(0, 0, 0, 0);
      chk("rst_restart", 64'(req_q[0]), 64'(RV));

      // random stall, redirect and memory latency
      lat_cfg = 0;
      repeat (400) begin
         cycle($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0, $urandom, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and instruction-fetch sequencer at the head of the IF stage. It holds the PC, issues one fetch request at a time to instruction memory, and captures the returned word into a one-entry output register for IF/ID. It adds redirect (branch/jump/flush) handling, stall back-pressure and discarding of stale in-flight responses. It also adds a configurable reset vector and reset hold-off.

## Interface

Parameters:
- ADDR_W, 32, PC / fetch address width in bits.
- INST_W, 32, instruction word width in bits.
- RESET_VEC, 0, PC value loaded on reset; low log2(INST_BYTES) bits must be 0.
- INST_BYTES, 4, PC increment per instruction; must be a power of two.
- RESET_HOLD, 1, number of cycles ce_o stays low after rst deasserts; must be at least 1.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- stall_i, input, 1, downstream not ready; holds the output register.
- redirect_i, input, 1, load redirect_pc_i and flush.
- redirect_pc_i, input, ADDR_W, redirect target.
- if_req_o, output, 1, fetch request; single-cycle pulse.
- if_addr_o, output, ADDR_W, fetch address; valid when if_req_o=1.
- if_ack_i, input, 1, memory response valid; one per request, at least 1 cycle after the request.
- if_rdata_i, input, INST_W, response data; valid when if_ack_i=1.
- ce_o, output, 1, fetch enable to instruction memory.
- inst_valid_o, output, 1, output register holds an instruction.
- inst_o, output, INST_W, fetched instruction.
- inst_pc_o, output, ADDR_W, address of inst_o.

## Operation

- **Reset (rst=1)**
  - Enters state HOLD with hold counter cleared.
  - pc=RESET_VEC, ce_o=0, if_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - Reset overrides every other input. Reset mid-fetch abandons the request; a late if_ack_i after reset is ignored (HOLD/ISSUE ignore ack).
- **States**
  - **HOLD**
    - Counts RESET_HOLD cycles, then moves to ISSUE with ce_o=1.
    - redirect_i in HOLD loads pc; the state stays HOLD.
  - **ISSUE**
    - if_req_o = (state==ISSUE) & ~redirect_i & slot_free. This is combinational.
    - slot_free = ~inst_valid_o | ~stall_i.
    - When if_req_o=1: if_addr_o=pc, latch fetch_addr=pc, go to WAIT.
    - If redirect_i=1: no request, pc loads the target, stay in ISSUE.
  - **WAIT**
    - On if_ack_i & ~redirect_i: inst_o=if_rdata_i, inst_pc_o=fetch_addr, inst_valid_o=1, pc=fetch_addr+INST_BYTES, go to ISSUE.
    - On redirect_i & ~if_ack_i: pc loads the target, go to KILL.
    - On redirect_i & if_ack_i: the response is discarded, pc loads the target, go to ISSUE.
  - **KILL**
    - Waits for the stale if_ack_i, discards it, goes to ISSUE.
    - redirect_i in KILL updates pc and stays in KILL. If the ack arrives in the same cycle, go to ISSUE.
- **Output register**
  - Consumed in any cycle with inst_valid_o=1 and stall_i=0. It clears next edge unless it is refilled by an ack that same edge.
  - stall_i=1 holds inst_o, inst_pc_o and inst_valid_o unchanged.
  - redirect_i clears inst_valid_o at the next edge, regardless of stall_i.
- **Arithmetic**
  - The redirect target's low log2(INST_BYTES) bits are forced to 0.
  - pc+INST_BYTES wraps modulo 2^ADDR_W; the all-ones-aligned address wraps to 0 with no error.
- **Ordering rule:** at most one request is outstanding, so an ack never finds the output register occupied.

## Timing

- **After reset:** with rst low from edge E, ce_o=1 and if_req_o=1 (addr RESET_VEC) during the cycle following edge E+RESET_HOLD-1.
- **Zero-wait memory** (ack in the cycle after req):
  - request at cycle N;
  - ack at N+1;
  - inst_valid_o=1 at N+2, where the next request is also issued if not stalled.
  - Steady throughput is 1 instruction per 2 cycles.
- **Redirect-to-request latency:** 1 cycle from the ISSUE state. From WAIT/KILL it is ack arrival + 1.
- **Stall:** a stalled, valid output register blocks new requests. The request fires in the first cycle stall_i=0.

## Test plan

- **Reset and sequential fetch:** RESET_VEC=0x100, RESET_HOLD=2, zero-wait ack, no stall.
  - ce_o=0 for 2 cycles after rst falls.
  - Requests to 0x100, 0x104, 0x108, spaced 2 cycles apart.
  - inst_pc_o matches each request and inst_o equals if_rdata_i.
- **Stall hold:** assert stall_i for 5 cycles while inst_valid_o=1 (pc 0x104).
  - Outputs frozen and if_req_o=0 throughout.
  - Request to 0x108 in the first unstalled cycle.
- **Redirect in WAIT with 3-cycle ack latency:** redirect to 0x2002.
  - The stale ack's data never appears on inst_o.
  - Next request is to 0x2000.
- **Simultaneous redirect and ack:** redirect to 0x400 in the same cycle as the ack.
  - Response dropped, inst_valid_o=0, next cycle requests 0x400; no KILL.
- **Wrap-around:** redirect to 0xFFFFFFFC, ADDR_W=32.
  - Fetch at 0xFFFFFFFC, then the next request at 0x00000000.
- **Reset mid-fetch:** assert rst during WAIT with ack arriving 1 cycle later.
  - All outputs at reset values.
  - The ack is ignored, and after hold the fetch restarts at RESET_VEC.
